// File: rtl/mc_pkg.sv
// Shared types and helpers for the matrix-converter commutation controller.
// Gate bit layout: gate[phase*2*num_in + 2*switch + polarity], polarity 0 = positive device.
package mc_pkg;

  typedef enum logic [2:0] {
    CH_OPEN,
    CH_ON,
    CH_S1,
    CH_S2,
    CH_S3,
    CH_S4
  } ch_state_e;

  localparam logic POL_P = 1'b0;
  localparam logic POL_N = 1'b1;

  function automatic int gate_idx(input int phase, input int sw, input logic neg,
                                  input int num_in);
    return phase * 2 * num_in + 2 * sw + (neg ? 1 : 0);
  endfunction

  // The select field must be wide enough to address every input switch.
  function automatic bit sel_w_ok(input int num_in, input int sel_w);
    return (num_in >= 1) && (sel_w >= 1) && (sel_w < 31) && (num_in <= (1 << sel_w));
  endfunction

endpackage

// File: rtl/mc_commutation_ch.sv
// One output phase: four-step, current-direction-aware commutation between input switches.
// Gates are registered from the next state so they change on the same edge as the FSM.
module mc_commutation_ch
  import mc_pkg::*;
#(
  parameter int NUM_IN   = 3,
  parameter int SEL_W    = 2,
  parameter int STEP_CYC = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  logic                enable,
  input  logic [SEL_W-1:0]    sel,
  input  logic                dir,
  output logic [2*NUM_IN-1:0] gate,
  output logic                busy,
  output logic                bad_sel
);

  localparam int CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYC - 1);

  ch_state_e           state_q, state_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [SEL_W-1:0]    nxt_q, nxt_d;
  logic                dir_q, dir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*NUM_IN-1:0] gate_d;
  logic                sel_ok;
  logic                step_done;

  assign sel_ok    = (int'(sel) < NUM_IN);
  assign bad_sel   = ~sel_ok;
  assign step_done = (cnt_q == CNT_LAST);
  assign busy      = (state_q inside {CH_S1, CH_S2, CH_S3, CH_S4});

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CH_OPEN: begin
        if (enable && sel_ok) begin
          state_d = CH_ON;
          cur_d   = sel;
        end
      end
      CH_ON: begin
        if (sel_ok && (sel != cur_q)) begin
          state_d = CH_S1;
          nxt_d   = sel;
          dir_d   = dir;
          cnt_d   = '0;
        end
      end
      CH_S1, CH_S2, CH_S3, CH_S4: begin
        if (step_done) begin
          cnt_d = '0;
          unique case (state_q)
            CH_S1:   state_d = CH_S2;
            CH_S2:   state_d = CH_S3;
            CH_S3:   state_d = CH_S4;
            default: begin
              state_d = CH_ON;
              cur_d   = nxt_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = CH_OPEN;
    endcase
    if (kill) begin
      state_d = CH_OPEN;
      cnt_d   = '0;
    end
  end

  // Conducting device c follows the latched current sign; n is the other device of the pair.
  always_comb begin
    logic is_cur;
    logic is_nxt;
    logic on_c;
    logic on_n;
    gate_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      is_cur = (int'(cur_d) == i);
      is_nxt = (int'(nxt_d) == i);
      on_c   = 1'b0;
      on_n   = 1'b0;
      unique case (state_d)
        CH_ON: begin
          on_c = is_cur;
          on_n = is_cur;
        end
        CH_S1: on_c = is_cur;
        CH_S2: on_c = is_cur | is_nxt;
        CH_S3: on_c = is_nxt;
        CH_S4: begin
          on_c = is_nxt;
          on_n = is_nxt;
        end
        default: ;
      endcase
      gate_d[gate_idx(0, i, POL_P, NUM_IN)] = dir_d ? on_c : on_n;
      gate_d[gate_idx(0, i, POL_N, NUM_IN)] = dir_d ? on_n : on_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_OPEN;
      cur_q   <= '0;
      nxt_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      gate    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      gate    <= gate_d;
    end
  end

endmodule

// File: rtl/mc_commutation_ctrl.sv
// Matrix-converter switch controller: per-phase commutation channels, latched clamp fault,
// command-error flag and a prescaled periodic control-loop interrupt.
module mc_commutation_ctrl
  import mc_pkg::*;
#(
  parameter int NUM_IN   = 3,
  parameter int NUM_OUT  = 3,
  parameter int SEL_W    = 2,
  parameter int STEP_CYC = 200,
  parameter int PRESCALE = 200,
  parameter int INT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_OUT*SEL_W-1:0]    sel,
  input  logic [NUM_OUT-1:0]          dir,
  input  logic                        clamp_in,
  input  logic                        fault_clr,
  input  logic [INT_W-1:0]            int_limit,
  output logic [NUM_OUT*2*NUM_IN-1:0] gate,
  output logic [NUM_OUT-1:0]          busy,
  output logic                        fault,
  output logic                        cmd_err,
  output logic                        interrupt
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  if (!sel_w_ok(NUM_IN, SEL_W)) begin : g_bad_cfg
    $error("mc_commutation_ctrl: SEL_W too narrow for NUM_IN");
  end

  logic [NUM_OUT*2*NUM_IN-1:0] ch_gate;
  logic [NUM_OUT-1:0]          bad_sel;
  logic                        run_en;
  logic [PRE_W-1:0]            pre_q;
  logic [INT_W-1:0]            int_cnt_q;
  logic                        tick;
  logic                        wrap;

  assign run_en = ~fault;

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_ch
    mc_commutation_ch #(
      .NUM_IN  (NUM_IN),
      .SEL_W   (SEL_W),
      .STEP_CYC(STEP_CYC)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .kill   (clamp_in),
      .enable (run_en),
      .sel    (sel[o*SEL_W +: SEL_W]),
      .dir    (dir[o]),
      .gate   (ch_gate[gate_idx(o, 0, POL_P, NUM_IN) +: 2*NUM_IN]),
      .busy   (busy[o]),
      .bad_sel(bad_sel[o])
    );
  end

  // Channels already open on clamp; the mask keeps every gate low for as long as fault is latched.
  assign gate = fault ? '0 : ch_gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= |bad_sel;
      if (clamp_in) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
    end
  end

  // A lowered int_limit below the running count wraps at the next tick.
  assign tick = (pre_q == PRE_LAST);
  assign wrap = (int_limit != '0) && (int_cnt_q >= (int_limit - INT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      int_cnt_q <= '0;
      interrupt <= 1'b0;
    end else begin
      pre_q     <= tick ? '0 : pre_q + PRE_W'(1);
      interrupt <= tick & wrap;
      if (tick) begin
        if ((int_limit == '0) || wrap) begin
          int_cnt_q <= '0;
        end else begin
          int_cnt_q <= int_cnt_q + INT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_commutation_ctrl.sv
// Self-checking bench: directed commutation/clamp/interrupt steps, then random sel/dir/clamp traffic,
// all compared each cycle against a time-based reference model of the commutation sequence.
module tb_mc_commutation_ctrl;

  localparam int NI   = 3;
  localparam int NO   = 3;
  localparam int SW   = 2;
  localparam int STEP = 4;
  localparam int PRE  = 2;
  localparam int IW   = 16;
  localparam int GW   = NO * 2 * NI;

  logic            clk = 1'b0;
  logic            rst;
  logic [NO*SW-1:0] sel;
  logic [NO-1:0]   dir;
  logic            clamp_in;
  logic            fault_clr;
  logic [IW-1:0]   int_limit;
  logic [GW-1:0]   gate;
  logic [NO-1:0]   busy;
  logic            fault;
  logic            cmd_err;
  logic            interrupt;

  int errors = 0;
  int checks = 0;

  // Reference model: per phase, conducting switch k, target j, latched dir, and cycles since
  // the commutation began (-1 when steady).
  bit m_on  [NO];
  int m_k   [NO];
  int m_j   [NO];
  int m_t   [NO];
  bit m_dir [NO];
  bit m_fault;
  bit m_cmd_err;
  bit chk_int = 1'b1;
  int cyc = 0;

  mc_commutation_ctrl #(
    .NUM_IN  (NI),
    .NUM_OUT (NO),
    .SEL_W   (SW),
    .STEP_CYC(STEP),
    .PRESCALE(PRE),
    .INT_W   (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .dir      (dir),
    .clamp_in (clamp_in),
    .fault_clr(fault_clr),
    .int_limit(int_limit),
    .gate     (gate),
    .busy     (busy),
    .fault    (fault),
    .cmd_err  (cmd_err),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update();
    bit bad;
    int s;
    bad = 1'b0;
    for (int o = 0; o < NO; o++) if (int'(sel[o*SW +: SW]) >= NI) bad = 1'b1;
    m_cmd_err = !rst && bad;
    if (rst) begin
      m_fault = 1'b0;
      for (int o = 0; o < NO; o++) begin
        m_on[o] = 1'b0; m_k[o] = 0; m_t[o] = -1;
      end
    end else if (clamp_in) begin
      m_fault = 1'b1;
      for (int o = 0; o < NO; o++) begin
        m_on[o] = 1'b0; m_t[o] = -1;
      end
    end else begin
      for (int o = 0; o < NO; o++) begin
        s = int'(sel[o*SW +: SW]);
        if (!m_on[o]) begin
          if (!m_fault && s < NI) begin
            m_on[o] = 1'b1; m_k[o] = s; m_t[o] = -1;
          end
        end else if (m_t[o] < 0) begin
          if (s < NI && s != m_k[o]) begin
            m_j[o] = s; m_dir[o] = dir[o]; m_t[o] = 0;
          end
        end else begin
          m_t[o]++;
          if (m_t[o] == 4 * STEP) begin
            m_k[o] = m_j[o]; m_t[o] = -1;
          end
        end
      end
      if (fault_clr) m_fault = 1'b0;
    end
    cyc++;
  endtask

  function automatic logic [GW-1:0] exp_gate();
    logic [GW-1:0] g;
    int b;
    int c;
    int n;
    g = '0;
    for (int o = 0; o < NO; o++) begin
      if (m_on[o]) begin
        b = o * 2 * NI;
        c = m_dir[o] ? 0 : 1;
        n = 1 - c;
        if (m_t[o] < 0) begin
          g[b + 2*m_k[o]] = 1'b1;
          g[b + 2*m_k[o] + 1] = 1'b1;
        end else begin
          case (m_t[o] / STEP)
            0: g[b + 2*m_k[o] + c] = 1'b1;
            1: begin
              g[b + 2*m_k[o] + c] = 1'b1;
              g[b + 2*m_j[o] + c] = 1'b1;
            end
            2: g[b + 2*m_j[o] + c] = 1'b1;
            default: begin
              g[b + 2*m_j[o] + c] = 1'b1;
              g[b + 2*m_j[o] + n] = 1'b1;
            end
          endcase
        end
      end
    end
    return g;
  endfunction

  task automatic compare();
    logic [NO-1:0] eb;
    int full;
    int any;
    for (int o = 0; o < NO; o++) eb[o] = m_on[o] && (m_t[o] >= 0);
    check("gate", 64'(gate), 64'(exp_gate()));
    check("busy", 64'(busy), 64'(eb));
    check("fault", 64'(fault), 64'(m_fault));
    check("cmd_err", 64'(cmd_err), 64'(m_cmd_err));
    if (chk_int) check("interrupt_idle", 64'(interrupt), 64'(0));
    for (int o = 0; o < NO; o++) begin
      full = 0;
      any  = 0;
      for (int i = 0; i < NI; i++) begin
        if (gate[o*2*NI + 2*i] && gate[o*2*NI + 2*i + 1]) full++;
        if (gate[o*2*NI + 2*i] || gate[o*2*NI + 2*i + 1]) any++;
      end
      check("safety_full_pairs", 64'(full <= 1), 64'(1));
      if (busy[o]) check("safety_path", 64'(any > 0), 64'(1));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  initial begin
    int busy_cnt;
    int n_int;
    int last_int;
    int o;

    // Reset state
    rst = 1'b1; sel = '0; dir = '1; clamp_in = 1'b0; fault_clr = 1'b0; int_limit = '0;
    repeat (3) cycle();
    check("rst_gate", 64'(gate), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_fault", 64'(fault), 64'(0));
    check("rst_cmd_err", 64'(cmd_err), 64'(0));

    // T1: direct turn-on of switch 0 on every phase one cycle after reset release
    rst = 1'b0;
    cycle();
    check("t1_gate", 64'(gate), 64'({3{6'b000011}}));
    check("t1_busy", 64'(busy), 64'(0));

    // T2: phase 0, dir=1, commutate 0 -> 2
    sel[1:0] = 2'd2;
    busy_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (busy[0]) busy_cnt++;
      if (i == 5) check("t2_s2_gate", 64'(gate[5:0]), 64'(6'b010001));
    end
    check("t2_busy_len", 64'(busy_cnt), 64'(16));
    check("t2_final", 64'(gate[5:0]), 64'(6'b110000));

    // T3: dir=0, commutate 2 -> 0; dir flipped during S2 must not change the sequence
    dir[0] = 1'b0;
    sel[1:0] = 2'd0;
    busy_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (busy[0]) busy_cnt++;
      if (i == 5) check("t3_s2_gate", 64'(gate[5:0]), 64'(6'b100010));
      if (i == 6) dir[0] = 1'b1;
      if (i == 9) check("t3_s3_gate", 64'(gate[5:0]), 64'(6'b000010));
    end
    check("t3_busy_len", 64'(busy_cnt), 64'(16));

    // T4: clamp during S3, clear ignored while clamped, then clear and direct turn-on
    sel[1:0] = 2'd1;
    repeat (9) cycle();
    check("t4_in_s3", 64'(busy[0]), 64'(1));
    clamp_in = 1'b1;
    cycle();
    check("t4_clamp_gate", 64'(gate), 64'(0));
    check("t4_clamp_fault", 64'(fault), 64'(1));
    fault_clr = 1'b1;
    repeat (2) cycle();
    check("t4_clr_ignored", 64'(fault), 64'(1));
    clamp_in = 1'b0;
    cycle();
    check("t4_cleared", 64'(fault), 64'(0));
    check("t4_still_open", 64'(gate), 64'(0));
    fault_clr = 1'b0;
    cycle();
    check("t4_turn_on", 64'(gate), 64'({6'b000011, 6'b000011, 6'b001100}));
    check("t4_no_busy", 64'(busy), 64'(0));

    // T5: out-of-range select
    sel[1:0] = 2'd3;
    cycle();
    check("t5_cmd_err", 64'(cmd_err), 64'(1));
    check("t5_gate_hold", 64'(gate), 64'({6'b000011, 6'b000011, 6'b001100}));
    sel[1:0] = 2'd1;
    cycle();
    check("t5_cmd_err_clear", 64'(cmd_err), 64'(0));

    // Interrupt: int_limit=5 ticks of PRE clocks -> one pulse every 10 clocks
    chk_int = 1'b0;
    int_limit = 16'd5;
    n_int = 0;
    last_int = -1;
    for (int i = 0; i < 65; i++) begin
      cycle();
      if (interrupt === 1'b1) begin
        if (last_int >= 0) check("int_period", 64'(cyc - last_int), 64'(10));
        last_int = cyc;
        n_int++;
      end
    end
    check("int_count", 64'(n_int >= 5), 64'(1));
    int_limit = 16'd0;
    cycle();
    chk_int = 1'b1;
    repeat (40) cycle();

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        o = $urandom_range(0, NO - 1);
        sel[o*SW +: SW] = SW'($urandom_range(0, 3));
      end
      dir       = NO'($urandom);
      clamp_in  = ($urandom_range(0, 99) < 2);
      fault_clr = ($urandom_range(0, 7) == 0);
      cycle();
    end
    clamp_in = 1'b0;
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;

    // Reset mid-commutation forces all gates off on the next edge
    sel = {2'd0, 2'd0, 2'd0};
    repeat (20) cycle();
    sel[1:0] = 2'd2;
    repeat (3) cycle();
    check("rst_mid_busy", 64'(busy[0]), 64'(1));
    rst = 1'b1;
    cycle();
    check("rst_mid_gate", 64'(gate), 64'(0));
    check("rst_mid_busy_clr", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
